// File: rtl/ssd_scan_controller_pkg.sv
// Shared constants and scan-state encoding for the seven-segment scan controller.
package ssd_scan_controller_pkg;

    localparam int SSD_CODE_W = 5;

    localparam logic [SSD_CODE_W-1:0] CODE_BLANK = 5'd30;
    localparam logic [SSD_CODE_W-1:0] CODE_L     = 5'd24;
    localparam logic [SSD_CODE_W-1:0] CODE_I     = 5'd23;
    localparam logic [SSD_CODE_W-1:0] CODE_A     = 5'd22;
    localparam logic [SSD_CODE_W-1:0] CODE_F     = 5'd21;
    localparam logic [SSD_CODE_W-1:0] CODE_E     = 5'd27;
    localparam logic [SSD_CODE_W-1:0] CODE_D     = 5'd28;

    typedef enum logic {
        ST_DRIVE = 1'b0,
        ST_BLANK = 1'b1
    } scan_state_e;

endpackage

// File: rtl/ssd_frame_buffer.sv
// Double-buffered frame store: a pending slot filled by the valid/ready handshake and an
// active frame that only changes at a frame boundary.
module ssd_frame_buffer
    import ssd_scan_controller_pkg::*;
#(
    parameter int                    NUM_DIGITS = 8,
    parameter logic [SSD_CODE_W-1:0] BLANK_CODE = CODE_BLANK
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [SSD_CODE_W*NUM_DIGITS-1:0] frame_data_i,
    input  logic                             frame_valid_i,
    output logic                             frame_ready_o,
    input  logic                             boundary_i,
    output logic [SSD_CODE_W*NUM_DIGITS-1:0] active_o
);

    localparam int FRAME_W = SSD_CODE_W * NUM_DIGITS;

    logic [FRAME_W-1:0] pending_q, pending_d;
    logic [FRAME_W-1:0] active_q, active_d;
    logic               pending_full_q, pending_full_d;
    logic               accept_s;

    assign accept_s      = frame_valid_i && !pending_full_q;
    assign frame_ready_o = !pending_full_q;
    assign active_o      = active_q;

    // Next-state: promote pending at the boundary, or bypass an empty pending slot.
    always_comb begin
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        active_d       = active_q;
        if (boundary_i) begin
            if (pending_full_q) begin
                active_d       = pending_q;
                pending_full_d = 1'b0;
            end else if (accept_s) begin
                active_d = frame_data_i;
            end else begin
                active_d = active_q;
            end
        end else if (accept_s) begin
            pending_d      = frame_data_i;
            pending_full_d = 1'b1;
        end else begin
            pending_full_d = pending_full_q;
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            active_q       <= {NUM_DIGITS{BLANK_CODE}};
        end else begin
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            active_q       <= active_d;
        end
    end

endmodule

// File: rtl/ssd_scan_controller.sv
// Scans an N-digit seven-segment display one digit per slot, with blanked dead time at the
// end of each slot and tear-free frame updates through ssd_frame_buffer.
module ssd_scan_controller
    import ssd_scan_controller_pkg::*;
#(
    parameter int                    NUM_DIGITS   = 8,
    parameter int                    DIGIT_CYCLES = 1000,
    parameter int                    DEAD_CYCLES  = 50,
    parameter logic [SSD_CODE_W-1:0] BLANK_CODE   = CODE_BLANK
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [SSD_CODE_W*NUM_DIGITS-1:0] frame_data,
    input  logic                             frame_valid,
    output logic                             frame_ready,
    input  logic [NUM_DIGITS-1:0]            digit_en,
    output logic [NUM_DIGITS-1:0]            ssdAnode,
    output logic [SSD_CODE_W-1:0]            ssdNumber,
    output logic                             frame_done
);

    localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRIVE_END = CNT_W'(DIGIT_CYCLES - DEAD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    scan_state_e                  state_q, state_d;
    logic [NUM_DIGITS-1:0]        anode_q, anode_d;
    logic [SSD_CODE_W-1:0]        number_q, number_d;
    logic                         done_q;
    logic                         cnt_wrap_s, boundary_s;
    logic [SSD_CODE_W*NUM_DIGITS-1:0] active_s;

    ssd_frame_buffer #(
        .NUM_DIGITS (NUM_DIGITS),
        .BLANK_CODE (BLANK_CODE)
    ) u_frame_buffer (
        .clk           (clk),
        .reset         (reset),
        .frame_data_i  (frame_data),
        .frame_valid_i (frame_valid),
        .frame_ready_o (frame_ready),
        .boundary_i    (boundary_s),
        .active_o      (active_s)
    );

    // Slot timing, digit advance and the output values for the current state/index.
    always_comb begin
        cnt_wrap_s = (cnt_q == CNT_LAST);
        boundary_s = cnt_wrap_s && (idx_q == IDX_LAST);
        if (cnt_wrap_s) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = idx_q;
        end
        state_d  = (cnt_d < DRIVE_END) ? ST_DRIVE : ST_BLANK;
        anode_d  = '1;
        number_d = BLANK_CODE;
        case (state_q)
            ST_DRIVE: begin
                if (digit_en[idx_q]) begin
                    anode_d[idx_q] = 1'b0;
                    number_d       = active_s[SSD_CODE_W*idx_q +: SSD_CODE_W];
                end else begin
                    anode_d  = '1;
                    number_d = BLANK_CODE;
                end
            end
            ST_BLANK: begin
                anode_d  = '1;
                number_d = BLANK_CODE;
            end
            default: begin
                anode_d  = '1;
                number_d = BLANK_CODE;
            end
        endcase
    end

    // Scan FSM with registered display outputs and frame-boundary pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            state_q  <= ST_DRIVE;
            anode_q  <= '1;
            number_q <= BLANK_CODE;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            state_q  <= state_d;
            anode_q  <= anode_d;
            number_q <= number_d;
            done_q   <= boundary_s;
        end
    end

    assign ssdAnode   = anode_q;
    assign ssdNumber  = number_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Randomized self-checking bench for ssd_scan_controller against a cycle-count reference model.
module tb_ssd_scan_controller;

    localparam int N    = 4;
    localparam int DC   = 4;
    localparam int DEAD = 1;
    localparam int FR   = N * DC;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [5*N-1:0] frame_data = '0;
    logic           frame_valid = 1'b0;
    logic           frame_ready;
    logic [N-1:0]   digit_en = '1;
    logic [N-1:0]   ssdAnode;
    logic [4:0]     ssdNumber;
    logic           frame_done;

    int tests = 0;
    int fails = 0;

    // Reference model: timeline position and the two frame buffers.
    int          cyc;
    logic [4:0]  act [N];
    logic [4:0]  pend [N];
    bit          pend_full;
    logic [N-1:0] exp_anode;
    logic [4:0]  exp_num;
    logic        exp_done, exp_ready, obs_ready;

    ssd_scan_controller #(
        .NUM_DIGITS   (N),
        .DIGIT_CYCLES (DC),
        .DEAD_CYCLES  (DEAD),
        .BLANK_CODE   (5'd30)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .digit_en    (digit_en),
        .ssdAnode    (ssdAnode),
        .ssdNumber   (ssdNumber),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    // At most one anode may be low in any cycle.
    always @(negedge clk) begin
        tests++;
        if ($countones(~ssdAnode) > 1) begin
            fails++;
            $display("FAIL one_hot_anode t=%0t anode=%b required at most one zero", $time, ssdAnode);
        end
    end

    task automatic model_reset();
        cyc       = 0;
        pend_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            act[i]  = 5'd30;
            pend[i] = 5'd30;
        end
    endtask

    // Predict the outputs of the coming edge, apply the frame rules, then take the edge.
    task automatic tick();
        int cnt, idx;
        bit drive, boundary, accept;
        logic [N-1:0] sel;
        cnt       = cyc % DC;
        idx       = (cyc / DC) % N;
        drive     = (cnt < DC - DEAD);
        boundary  = (idx == N - 1) && (cnt == DC - 1);
        exp_ready = !pend_full;
        obs_ready = frame_ready;
        exp_done  = boundary;
        exp_anode = '1;
        exp_num   = 5'd30;
        if (drive && digit_en[idx]) begin
            sel      = '0;
            sel[idx] = 1'b1;
            exp_anode = ~sel;
            exp_num   = act[idx];
        end
        accept = frame_valid && !pend_full;
        if (boundary) begin
            if (pend_full) begin
                for (int i = 0; i < N; i++) act[i] = pend[i];
                pend_full = 1'b0;
            end else if (accept) begin
                for (int i = 0; i < N; i++) act[i] = frame_data[5*i +: 5];
            end
        end else if (accept) begin
            for (int i = 0; i < N; i++) pend[i] = frame_data[5*i +: 5];
            pend_full = 1'b1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic advance(input int phase);
        int guard = 0;
        while ((cyc % FR) != phase && guard < 2 * FR) begin
            tick();
            guard++;
        end
    endtask

    task automatic random_frame();
        for (int i = 0; i < N; i++) frame_data[5*i +: 5] = 5'($urandom_range(0, 29));
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({ssdAnode, ssdNumber, frame_done, frame_ready} !== {4'hF, 5'd30, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset_state anode=%b num=%0d done=%b ready=%b required 1111/30/0/1",
                     ssdAnode, ssdNumber, frame_done, frame_ready);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_idle_scan();
        int done_cnt = 0;
        repeat (2 * FR) begin
            tick();
            done_cnt += int'(frame_done);
            tests++;
            if ({ssdAnode, ssdNumber, frame_done, obs_ready} !== {exp_anode, exp_num, exp_done, exp_ready}) begin
                fails++;
                $display("FAIL idle_scan cyc=%0d anode=%b/%b num=%0d/%0d done=%b/%b ready=%b/%b", cyc,
                         ssdAnode, exp_anode, ssdNumber, exp_num, frame_done, exp_done, obs_ready, exp_ready);
            end
        end
        tests++;
        if (done_cnt != 2) begin
            fails++;
            $display("FAIL idle_frame_done_count got %0d required 2", done_cnt);
        end
    endtask

    task automatic test_load_midframe();
        advance(6);
        frame_data  = {5'd3, 5'd2, 5'd1, 5'd0};
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        repeat (2 * FR) begin
            tick();
            tests++;
            if ({ssdAnode, ssdNumber, frame_done, obs_ready} !== {exp_anode, exp_num, exp_done, exp_ready}) begin
                fails++;
                $display("FAIL load_midframe cyc=%0d anode=%b/%b num=%0d/%0d done=%b/%b ready=%b/%b", cyc,
                         ssdAnode, exp_anode, ssdNumber, exp_num, frame_done, exp_done, obs_ready, exp_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit taken = 1'b0;
        advance(3);
        random_frame();
        frame_valid = 1'b1;
        tick();
        random_frame();
        for (int k = 0; k < 3 * FR && !taken; k++) begin
            tick();
            taken = obs_ready;
            tests++;
            if ({ssdAnode, ssdNumber, frame_done, obs_ready} !== {exp_anode, exp_num, exp_done, exp_ready}) begin
                fails++;
                $display("FAIL back_to_back_wait cyc=%0d anode=%b/%b num=%0d/%0d ready=%b/%b", cyc,
                         ssdAnode, exp_anode, ssdNumber, exp_num, obs_ready, exp_ready);
            end
        end
        frame_valid = 1'b0;
        tests++;
        if (!taken) begin
            fails++;
            $display("FAIL back_to_back_timeout frame B accepted=%b required 1", taken);
        end
        repeat (3 * FR) begin
            tick();
            tests++;
            if ({ssdAnode, ssdNumber, frame_done, obs_ready} !== {exp_anode, exp_num, exp_done, exp_ready}) begin
                fails++;
                $display("FAIL back_to_back_show cyc=%0d anode=%b/%b num=%0d/%0d ready=%b/%b", cyc,
                         ssdAnode, exp_anode, ssdNumber, exp_num, obs_ready, exp_ready);
            end
        end
    endtask

    task automatic test_bypass();
        advance(FR - 1);
        random_frame();
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        tests++;
        if (frame_ready !== 1'b1) begin
            fails++;
            $display("FAIL bypass_ready got %b required 1", frame_ready);
        end
        repeat (FR) begin
            tick();
            tests++;
            if ({ssdAnode, ssdNumber, frame_done, obs_ready} !== {exp_anode, exp_num, exp_done, exp_ready}) begin
                fails++;
                $display("FAIL bypass cyc=%0d anode=%b/%b num=%0d/%0d ready=%b/%b", cyc,
                         ssdAnode, exp_anode, ssdNumber, exp_num, obs_ready, exp_ready);
            end
        end
    endtask

    task automatic test_digit_en();
        advance(5);
        random_frame();
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        digit_en = 4'b1011;
        repeat (2 * FR) begin
            tick();
            tests++;
            if ({ssdAnode, ssdNumber, frame_done, obs_ready} !== {exp_anode, exp_num, exp_done, exp_ready}) begin
                fails++;
                $display("FAIL digit_en cyc=%0d anode=%b/%b num=%0d/%0d done=%b/%b", cyc,
                         ssdAnode, exp_anode, ssdNumber, exp_num, frame_done, exp_done);
            end
        end
        digit_en = '1;
    endtask

    task automatic test_random();
        repeat (300) begin
            frame_valid = ($urandom_range(0, 7) == 0);
            random_frame();
            if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom_range(0, 15));
            tick();
            tests++;
            if ({ssdAnode, ssdNumber, frame_done, obs_ready} !== {exp_anode, exp_num, exp_done, exp_ready}) begin
                fails++;
                $display("FAIL random cyc=%0d anode=%b/%b num=%0d/%0d done=%b/%b ready=%b/%b", cyc,
                         ssdAnode, exp_anode, ssdNumber, exp_num, frame_done, exp_done, obs_ready, exp_ready);
            end
        end
        frame_valid = 1'b0;
        digit_en    = '1;
    endtask

    task automatic test_reset_midscan();
        advance(2);
        random_frame();
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        advance(2 * DC + 2);
        tests++;
        if (frame_ready !== 1'b0) begin
            fails++;
            $display("FAIL midscan_pending_full ready=%b required 0", frame_ready);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({ssdAnode, ssdNumber, frame_done, frame_ready} !== {4'hF, 5'd30, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL midscan_async_reset anode=%b num=%0d done=%b ready=%b required 1111/30/0/1",
                     ssdAnode, ssdNumber, frame_done, frame_ready);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        repeat (2 * FR) begin
            tick();
            tests++;
            if ({ssdAnode, ssdNumber, frame_done, obs_ready} !== {exp_anode, exp_num, exp_done, exp_ready}) begin
                fails++;
                $display("FAIL midscan_restart cyc=%0d anode=%b/%b num=%0d/%0d done=%b/%b ready=%b/%b", cyc,
                         ssdAnode, exp_anode, ssdNumber, exp_num, frame_done, exp_done, obs_ready, exp_ready);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle_scan();
        test_load_midframe();
        test_back_to_back();
        test_bypass();
        test_digit_en();
        test_random();
        test_reset_midscan();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
